// File: rtl/lcd_disp_ctrl.sv
// lcd_disp_ctrl: RGB LCD panel controller.
// After reset the pixel bus is released for a while, the panel ID straps
// (M0=lcd_rgb_in[7], M1=lcd_rgb_in[15], M2=lcd_rgb_in[23]) are read back, the
// matching panel timing is loaded once, and the sync/data-enable generator runs.
// The generator advances one pixel per pix_ce strobe.
//
// Ports:
//   sys_clk, sys_rst_n       - clock, asynchronous active-low reset
//   lcd_rgb_in[23:0]         - panel bus readback (ID straps)
//   pix_ce                   - one-cycle pixel strobe
//   rgb_oe                   - pixel source may drive the bus
//   lcd_hs, lcd_vs           - active-low syncs
//   lcd_de                   - active-high data enable
//   lcd_bl                   - backlight enable
//   pixel_xpos, pixel_ypos   - active-area coordinates (0 outside the active area)
//   lcd_id, pclk_div         - decoded panel ID and pixel clock divider code
//   cfg_done                 - timing loaded and generator running
//
// Build option: define LCD_ID_DEBOUNCE_EN to accept the straps only after three
// consecutive identical samples.
module lcd_disp_ctrl (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] lcd_rgb_in,
  input  logic        pix_ce,
  output logic        rgb_oe,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic        lcd_bl,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [15:0] lcd_id,
  output logic [1:0]  pclk_div,
  output logic        cfg_done
);

  typedef enum logic [1:0] {ST_WAIT, ST_SAMPLE, ST_CONFIG, ST_RUN} state_e;

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic [2:0]  id_code_q;
`ifdef LCD_ID_DEBOUNCE_EN
  logic [1:0]  stable_cnt_q;
`endif
  logic [10:0] h_cnt_q, v_cnt_q;
  logic [10:0] h_sync_q, h_start_q, h_end_q, h_total_q;
  logic [10:0] v_sync_q, v_start_q, v_end_q, v_total_q;
  logic [15:0] id_q;
  logic [1:0]  div_q;
  logic        hs_q, vs_q, de_q, bl_q, oe_q, done_q;
  logic [10:0] xpos_q, ypos_q;

  logic [15:0] id_d;
  logic [1:0]  div_d;
  logic [10:0] h_sync_d, h_start_d, h_end_d, h_total_d;
  logic [10:0] v_sync_d, v_start_d, v_end_d, v_total_d;
  logic        hs_d, vs_d, de_d, h_wrap, v_wrap;
  logic [10:0] xpos_d, ypos_d;

  logic [2:0]  straps;
  logic        unused_rgb;

  // Only the three strap bits matter; the rest of the bus is pixel data.
  assign straps     = {lcd_rgb_in[23], lcd_rgb_in[15], lcd_rgb_in[7]};
  assign unused_rgb = ^{lcd_rgb_in[22:16], lcd_rgb_in[14:8], lcd_rgb_in[6:0]};

  // Timing kept as sync end / active start / active end / total.
  always_comb begin
    id_d      = 16'h0000;
    div_d     = 2'd2;
    h_sync_d  = 11'd41;  h_start_d = 11'd43;  h_end_d = 11'd523;  h_total_d = 11'd525;
    v_sync_d  = 11'd10;  v_start_d = 11'd12;  v_end_d = 11'd284;  v_total_d = 11'd286;
    case (id_code_q)
      3'b000: id_d = 16'h4342;
      3'b001: begin
        id_d      = 16'h7084;
        div_d     = 2'd1;
        h_sync_d  = 11'd128; h_start_d = 11'd216; h_end_d = 11'd1016; h_total_d = 11'd1056;
        v_sync_d  = 11'd2;   v_start_d = 11'd35;  v_end_d = 11'd515;  v_total_d = 11'd525;
      end
      3'b010: begin
        id_d      = 16'h7016;
        div_d     = 2'd0;
        h_sync_d  = 11'd20;  h_start_d = 11'd160; h_end_d = 11'd1184; h_total_d = 11'd1344;
        v_sync_d  = 11'd3;   v_start_d = 11'd23;  v_end_d = 11'd623;  v_total_d = 11'd635;
      end
      default: ;
    endcase
  end

  always_comb begin
    hs_d   = !(h_cnt_q < h_sync_q);
    vs_d   = !(v_cnt_q < v_sync_q);
    de_d   = (h_cnt_q >= h_start_q) && (h_cnt_q < h_end_q) &&
             (v_cnt_q >= v_start_q) && (v_cnt_q < v_end_q);
    xpos_d = de_d ? (h_cnt_q - h_start_q) : '0;
    ypos_d = de_d ? (v_cnt_q - v_start_q) : '0;
    h_wrap = (h_cnt_q == h_total_q - 11'd1);
    v_wrap = (v_cnt_q == v_total_q - 11'd1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_WAIT;
      wait_cnt_q <= '0;
      id_code_q  <= '0;
`ifdef LCD_ID_DEBOUNCE_EN
      stable_cnt_q <= '0;
`endif
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      h_sync_q   <= '0;  h_start_q <= '0;  h_end_q <= '0;  h_total_q <= '0;
      v_sync_q   <= '0;  v_start_q <= '0;  v_end_q <= '0;  v_total_q <= '0;
      id_q       <= '0;
      div_q      <= 2'd2;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
      bl_q       <= 1'b0;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
          if (wait_cnt_q == 4'hF) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
`ifdef LCD_ID_DEBOUNCE_EN
          // The held code doubles as the comparison reference; a mismatch
          // restarts the run with the new value as its first sample.
          if (stable_cnt_q == 2'd0 || straps != id_code_q) begin
            id_code_q    <= straps;
            stable_cnt_q <= 2'd1;
          end else if (stable_cnt_q == 2'd2) begin
            state_q <= ST_CONFIG;
          end else begin
            stable_cnt_q <= stable_cnt_q + 2'd1;
          end
`else
          id_code_q <= straps;
          state_q   <= ST_CONFIG;
`endif
        end
        ST_CONFIG: begin
          id_q      <= id_d;
          div_q     <= div_d;
          h_sync_q  <= h_sync_d;  h_start_q <= h_start_d;
          h_end_q   <= h_end_d;   h_total_q <= h_total_d;
          v_sync_q  <= v_sync_d;  v_start_q <= v_start_d;
          v_end_q   <= v_end_d;   v_total_q <= v_total_d;
          h_cnt_q   <= '0;
          v_cnt_q   <= '0;
          bl_q      <= 1'b1;
          oe_q      <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= ST_RUN;
        end
        ST_RUN: begin
          hs_q   <= hs_d;
          vs_q   <= vs_d;
          de_q   <= de_d;
          xpos_q <= xpos_d;
          ypos_q <= ypos_d;
          if (pix_ce) begin
            if (h_wrap) begin
              h_cnt_q <= '0;
              v_cnt_q <= v_wrap ? '0 : v_cnt_q + 11'd1;
            end else begin
              h_cnt_q <= h_cnt_q + 11'd1;
            end
          end
        end
      endcase
    end
  end

  assign rgb_oe     = oe_q;
  assign lcd_hs     = hs_q;
  assign lcd_vs     = vs_q;
  assign lcd_de     = de_q;
  assign lcd_bl     = bl_q;
  assign pixel_xpos = xpos_q;
  assign pixel_ypos = ypos_q;
  assign lcd_id     = id_q;
  assign pclk_div   = div_q;
  assign cfg_done   = done_q;

endmodule

// File: doc/lcd_disp_ctrl.md
LCD_DISP_CTRL -- requirements
Module: lcd_disp_ctrl

Interface
REQ-001 The block SHALL have these ports, clock and reset first: sys_clk  in  1  single clock for all logic (50 MHz).
REQ-002 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-003 lcd_rgb_in  in  24  panel bus readback; ID straps M0=bit7, M1=bit15, M2=bit23.
REQ-004 pix_ce  in  1  one-sys_clk pixel strobe from the external clock generator.
REQ-005 rgb_oe  out  1  high = pixel source may drive lcd_rgb; low = bus released for ID read.
REQ-006 lcd_hs, lcd_vs  out  1 each  active-low syncs; lcd_de  out  1  active-high data enable; lcd_bl  out  1  backlight.
REQ-007 pixel_xpos, pixel_ypos  out  11 each  active-area coordinates.
REQ-008 lcd_id  out  16  decoded panel ID; pclk_div  out  2  divider code (0:/1, 1:/2, 2:/4); cfg_done  out  1  high in RUN.

Function
REQ-009 FSM states SHALL be WAIT, SAMPLE, CONFIG, RUN; WAIT->SAMPLE after 16 sys_clk cycles; SAMPLE->CONFIG on accepted ID; CONFIG->RUN after exactly 1 cycle; RUN is left only by reset.
REQ-010 ID code {M2,M1,M0} SHALL decode: 000 -> 16'h4342, pclk_div=2; 001 -> 16'h7084, pclk_div=1; 010 -> 16'h7016, pclk_div=0; others -> lcd_id=16'h0000 with 4342 timing and pclk_div=2.
REQ-011 Timing (sync, back, disp, front, total) H/V: 4342 H 41,2,480,2,525 V 10,2,272,2,286; 7084 H 128,88,800,40,1056 V 2,33,480,10,525; 7016 H 20,140,1024,160,1344 V 3,20,600,12,635.
REQ-012 lcd_id, pclk_div and timing registers SHALL load in CONFIG and hold until reset.
REQ-013 In RUN, h_cnt SHALL advance only on pix_ce, wrap from H_TOTAL-1 to 0, and v_cnt SHALL advance on that wrap, wrapping from V_TOTAL-1 to 0.
REQ-014 lcd_hs SHALL be low iff h_cnt < H_SYNC; lcd_vs SHALL be low iff v_cnt < V_SYNC.
REQ-015 lcd_de SHALL be high iff H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP and same for v_cnt with V parameters.
REQ-016 pixel_xpos/ypos SHALL equal h_cnt-(H_SYNC+H_BACK) / v_cnt-(V_SYNC+V_BACK) while lcd_de is high, else 0.
REQ-017 All syncs, lcd_de and coordinates SHALL be registered, one sys_clk after the counter value they reflect, mutually aligned.
REQ-018 rgb_oe, lcd_bl and cfg_done SHALL rise on the first RUN cycle and stay high; pix_ce SHALL be ignored outside RUN.
REQ-019 The first RUN frame SHALL start at h_cnt=0, v_cnt=0.

Reset
REQ-020 On sys_rst_n low, asynchronously: state=WAIT, counters=0, lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_bl=0, rgb_oe=0, cfg_done=0, coordinates=0, lcd_id=0, pclk_div=2.
REQ-021 Reset asserted mid-frame SHALL abort output immediately; release SHALL re-read the ID from WAIT.

Configuration
REQ-022 Macro LCD_ID_DEBOUNCE_EN defined: SAMPLE SHALL accept the ID only after 3 consecutive identical sys_clk samples; any mismatch restarts the count.
REQ-023 Macro LCD_ID_DEBOUNCE_EN undefined: SAMPLE SHALL accept the single sample taken on its first cycle.

Verification
REQ-024 Straps 000 (lcd_rgb_in=24'h000000), pix_ce every 4th cycle -> lcd_id=16'h4342, pclk_div=2, lcd_hs low 41 pix_ce per 525, lcd_de high 480 per line, 272 lines per 286.
REQ-025 Straps 001 (bit7 set, 24'h000080) -> lcd_id=16'h7084, pclk_div=1, lcd_de first at h_cnt=216, pixel_xpos 0..799.
REQ-026 Straps 010 (bit15 set) -> lcd_id=16'h7016, pclk_div=0, V_TOTAL=635 lines between lcd_vs falling edges.
REQ-027 Straps 111 -> lcd_id=16'h0000 with 4342 timing; rgb_oe low for all cycles before cfg_done.
REQ-028 With LCD_ID_DEBOUNCE_EN, strap toggling every cycle for 20 cycles then stable 001 -> no CONFIG until 3 stable samples, final lcd_id=16'h7084.
REQ-029 sys_rst_n pulsed low mid-active line -> outputs take REQ-020 values asynchronously; after release a fresh ID read and frame from h_cnt=0.
